// File: rtl/tow_pkg.sv
// tow_pkg: shared FSM/winner encodings and LFSR constants for the tug-of-war playfield
package tow_pkg;
    typedef enum logic [1:0] {PLAY = 2'd0, POINT = 2'd1, MATCH = 2'd2} state_e;
    typedef enum logic [1:0] {NONE = 2'b00, RIGHT = 2'b01, LEFT = 2'b10} winner_e;
    localparam logic [9:0] LFSR_SEED = 10'h001;
    localparam logic [9:0] LFSR_TAPS = 10'h240;
endpackage

// File: rtl/tow_lfsr.sv
// tow_lfsr: 10-bit Fibonacci LFSR (x^10+x^7+1) that advances every cycle
module tow_lfsr
    import tow_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] lfsr_o
);
    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;
    always_comb lfsr_d = {lfsr_q[8:0], ^(lfsr_q & LFSR_TAPS)};
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end
    assign lfsr_o = lfsr_q;
endmodule

// File: rtl/tow_playfield.sv
// tow_playfield: tug-of-war playfield FSM; define TOW_CPU_PLAYER_EN for an LFSR-driven left player
module tow_playfield
    import tow_pkg::*;
#(
    parameter int NUM_LIGHTS  = 9,
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef TOW_CPU_PLAYER_EN
    input  logic                  cpu_en,
    input  logic [3:0]            cpu_level,
`endif
    input  logic                  L,
    input  logic                  R,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]    score_l,
    output logic [SCORE_W-1:0]    score_r,
    output logic [1:0]            point_winner,
    output logic                  match_over
);
    localparam int PW = $clog2(NUM_LIGHTS);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int C  = (NUM_LIGHTS - 1) / 2;

    logic left;
`ifdef TOW_CPU_PLAYER_EN
    logic [9:0] lfsr;
    tow_lfsr u_lfsr (.clk(clk), .reset(reset), .lfsr_o(lfsr));
    assign left = cpu_en ? (lfsr < {cpu_level, 6'b0}) : L;
`else
    assign left = L;
`endif

    state_e                state_q, state_d;
    winner_e               winner_q, winner_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic [SCORE_W-1:0]    score_l_q, score_l_d, score_r_q, score_r_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [NUM_LIGHTS-1:0] lights_q, lights_d;
    logic                  match_q, match_d;

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        pos_d     = pos_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        hold_d    = hold_q;
        if (state_q == PLAY) begin
            if (left && !R) begin
                if (pos_q == PW'(NUM_LIGHTS - 1)) begin
                    score_l_d = score_l_q + 1'b1;
                    winner_d  = LEFT;
                    state_d   = (score_l_d == SCORE_W'(WIN_SCORE)) ? MATCH : POINT;
                    hold_d    = HW'(HOLD_CYCLES - 1);
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end else if (R && !left) begin
                if (pos_q == '0) begin
                    score_r_d = score_r_q + 1'b1;
                    winner_d  = RIGHT;
                    state_d   = (score_r_d == SCORE_W'(WIN_SCORE)) ? MATCH : POINT;
                    hold_d    = HW'(HOLD_CYCLES - 1);
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end
        end else if (state_q == POINT) begin
            // hold counts HOLD_CYCLES-1 down to 0, giving exactly HOLD_CYCLES dark cycles
            state_d = (hold_q == '0) ? PLAY : POINT;
            pos_d   = (hold_q == '0) ? PW'(C) : pos_q;
            hold_d  = (hold_q == '0) ? hold_q : hold_q - 1'b1;
        end
        lights_d = (state_d == PLAY) ? NUM_LIGHTS'(1) << pos_d : '0;
        match_d  = (state_d == MATCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PLAY;
            winner_q  <= NONE;
            pos_q     <= PW'(C);
            score_l_q <= '0;
            score_r_q <= '0;
            hold_q    <= '0;
            lights_q  <= NUM_LIGHTS'(1) << C;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            pos_q     <= pos_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            hold_q    <= hold_d;
            lights_q  <= lights_d;
            match_q   <= match_d;
        end
    end

    assign lights       = lights_q;
    assign score_l      = score_l_q;
    assign score_r      = score_r_q;
    assign point_winner = winner_q;
    assign match_over   = match_q;
endmodule

// File: tb/tb_tow_playfield.sv
// tb_tow_playfield: random and directed checks of two playfields (WIN_SCORE 7 and 2) against a score/position model
module tb_tow_playfield;
    localparam int N = 9;
    localparam int C = 4;
    localparam int HOLD = 4;

    logic clk = 0;
    logic reset = 0;
    logic L = 0;
    logic R = 0;
    logic [N-1:0] lt [2];
    logic [2:0]   slt [2];
    logic [2:0]   srt [2];
    logic [1:0]   pwt [2];
    logic         mot [2];

    int checks = 0;
    int failures = 0;

    int m_pos [2];
    int m_sl [2];
    int m_sr [2];
    int m_win [2];
    int m_hold [2];
    bit m_over [2];
    int win_score [2] = '{7, 2};

    always #5 clk = ~clk;

    tow_playfield u_dut0 (
        .clk(clk), .reset(reset),
`ifdef TOW_CPU_PLAYER_EN
        .cpu_en(1'b0), .cpu_level(4'h0),
`endif
        .L(L), .R(R), .lights(lt[0]), .score_l(slt[0]), .score_r(srt[0]),
        .point_winner(pwt[0]), .match_over(mot[0])
    );

    tow_playfield #(.WIN_SCORE(2)) u_dut1 (
        .clk(clk), .reset(reset),
`ifdef TOW_CPU_PLAYER_EN
        .cpu_en(1'b0), .cpu_level(4'h0),
`endif
        .L(L), .R(R), .lights(lt[1]), .score_l(slt[1]), .score_r(srt[1]),
        .point_winner(pwt[1]), .match_over(mot[1])
    );

    function automatic logic [N-1:0] exp_lights(int k);
        logic [N-1:0] one = 1;
        return (!m_over[k] && m_hold[k] == 0) ? one << m_pos[k] : '0;
    endfunction

    task automatic model_step(bit l, bit r);
        for (int k = 0; k < 2; k++) begin
            if (m_over[k]) continue;
            if (m_hold[k] > 0) begin
                m_hold[k]--;
                if (m_hold[k] == 0) m_pos[k] = C;
            end else if (l && !r) begin
                if (m_pos[k] == N - 1) begin
                    m_sl[k]++;
                    m_win[k] = 2;
                    if (m_sl[k] == win_score[k]) m_over[k] = 1; else m_hold[k] = HOLD;
                end else m_pos[k]++;
            end else if (r && !l) begin
                if (m_pos[k] == 0) begin
                    m_sr[k]++;
                    m_win[k] = 1;
                    if (m_sr[k] == win_score[k]) m_over[k] = 1; else m_hold[k] = HOLD;
                end else m_pos[k]--;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1; L = 0; R = 0;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_pos[k] = C; m_sl[k] = 0; m_sr[k] = 0; m_win[k] = 0; m_hold[k] = 0; m_over[k] = 0;
        end
        #1 reset = 0;
    endtask

    task automatic drive(bit l, bit r);
        L = l; R = r;
        @(posedge clk);
        model_step(l, r);
        #1 L = 0; R = 0;
    endtask

    task automatic test_reset();
        drive(0, 1); drive(0, 1);
        do_reset();
        checks++; if (lt[0] !== 9'b000010000) begin failures++; $display("FAIL reset_lights got=%b exp=%b", lt[0], 9'b000010000); end
        checks++; if (slt[0] !== 3'd0 || srt[0] !== 3'd0) begin failures++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", slt[0], srt[0]); end
        checks++; if (pwt[0] !== 2'b00) begin failures++; $display("FAIL reset_winner got=%b exp=00", pwt[0]); end
        checks++; if (mot[0] !== 1'b0) begin failures++; $display("FAIL reset_match got=%b exp=0", mot[0]); end
    endtask

    task automatic test_move();
        do_reset();
        drive(0, 1); drive(0, 1);
        checks++; if (lt[0] !== 9'b000000100) begin failures++; $display("FAIL move_right got=%b exp=%b", lt[0], 9'b000000100); end
        drive(1, 0);
        checks++; if (lt[0] !== 9'b000001000) begin failures++; $display("FAIL move_left got=%b exp=%b", lt[0], 9'b000001000); end
    endtask

    task automatic test_both();
        do_reset();
        drive(1, 1);
        checks++; if (lt[0] !== 9'b000010000) begin failures++; $display("FAIL both_pressed got=%b exp=%b", lt[0], 9'b000010000); end
    endtask

    task automatic test_point();
        do_reset();
        repeat (5) drive(0, 1);
        checks++; if (srt[0] !== 3'd1) begin failures++; $display("FAIL point_score_r got=%0d exp=1", srt[0]); end
        checks++; if (pwt[0] !== 2'b01) begin failures++; $display("FAIL point_winner got=%b exp=01", pwt[0]); end
        checks++; if (lt[0] !== '0) begin failures++; $display("FAIL point_dark0 got=%b exp=0", lt[0]); end
        for (int i = 1; i < HOLD; i++) begin
            drive(i[0], !i[0]);
            checks++; if (lt[0] !== '0) begin failures++; $display("FAIL point_dark%0d got=%b exp=0", i, lt[0]); end
        end
        drive(0, 0);
        checks++; if (lt[0] !== 9'b000010000) begin failures++; $display("FAIL point_resume got=%b exp=%b", lt[0], 9'b000010000); end
        checks++; if (pwt[0] !== 2'b01 || srt[0] !== 3'd1 || slt[0] !== 3'd0) begin failures++; $display("FAIL point_hold got=%b/%0d/%0d exp=01/1/0", pwt[0], srt[0], slt[0]); end
    endtask

    task automatic test_match();
        do_reset();
        repeat (5) drive(1, 0);
        repeat (HOLD) drive(0, 0);
        repeat (5) drive(1, 0);
        checks++; if (slt[1] !== 3'd2) begin failures++; $display("FAIL match_score_l got=%0d exp=2", slt[1]); end
        checks++; if (mot[1] !== 1'b1) begin failures++; $display("FAIL match_over got=%b exp=1", mot[1]); end
        checks++; if (lt[1] !== '0) begin failures++; $display("FAIL match_lights got=%b exp=0", lt[1]); end
        for (int i = 0; i < 12; i++) drive(1'($urandom), 1'($urandom));
        checks++; if (slt[1] !== 3'd2 || srt[1] !== 3'd0 || pwt[1] !== 2'b10 || mot[1] !== 1'b1 || lt[1] !== '0) begin
            failures++; $display("FAIL match_frozen got=%0d/%0d/%b/%b/%b exp=2/0/10/1/0", slt[1], srt[1], pwt[1], mot[1], lt[1]);
        end
    endtask

    task automatic test_reset_mid_point();
        do_reset();
        repeat (5) drive(0, 1);
        drive(0, 0);
        do_reset();
        checks++; if (lt[0] !== 9'b000010000) begin failures++; $display("FAIL midpoint_lights got=%b exp=%b", lt[0], 9'b000010000); end
        checks++; if (slt[0] !== 3'd0 || srt[0] !== 3'd0 || pwt[0] !== 2'b00) begin failures++; $display("FAIL midpoint_state got=%0d/%0d/%b exp=0/0/00", slt[0], srt[0], pwt[0]); end
    endtask

    task automatic test_random();
        int bias_l = 50;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) bias_l = 20 + 20 * int'($urandom_range(3));
            if ($urandom_range(499) == 0) do_reset();
            else drive($urandom_range(99) < bias_l, $urandom_range(99) < 100 - bias_l);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (lt[k] !== exp_lights(k) || slt[k] !== 3'(m_sl[k]) || srt[k] !== 3'(m_sr[k]) || pwt[k] !== 2'(m_win[k]) || mot[k] !== m_over[k]) begin
                    failures++;
                    $display("FAIL random k=%0d cyc=%0d got=%b/%0d/%0d/%b/%b exp=%b/%0d/%0d/%0d/%b", k, i, lt[k], slt[k], srt[k], pwt[k], mot[k], exp_lights(k), m_sl[k], m_sr[k], m_win[k], m_over[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_both();
        test_point();
        test_match();
        test_reset_mid_point();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
